// File: rtl/perceptron_pkg.sv
// Shared defaults and FSM state encoding for the perceptron sample sequencer.
package perceptron_pkg;

  localparam int unsigned DATA_W      = 4;
  localparam int unsigned NUM_SAMPLES = 3;
  localparam int unsigned NUM_EPOCHS  = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/perceptron_sample_sequencer_if.sv
// Load and sample-stream handshakes between the sequencer and its neighbours.
interface perceptron_sample_sequencer_if #(
  parameter int unsigned DATA_W = perceptron_pkg::DATA_W
);

  logic              load_valid;
  logic [2*DATA_W:0] load_data;
  logic              load_ready;

  logic              smp_valid;
  logic              smp_ready;
  logic [DATA_W-1:0] smp_x0;
  logic [DATA_W-1:0] smp_x1;
  logic              smp_label;
  logic              smp_last;

  modport master (
    input  load_valid, load_data, smp_ready,
    output load_ready, smp_valid, smp_x0, smp_x1, smp_label, smp_last
  );

  modport slave (
    output load_valid, load_data, smp_ready,
    input  load_ready, smp_valid, smp_x0, smp_x1, smp_label, smp_last
  );

endinterface

// File: rtl/perceptron_sample_buffer.sv
// Training-sample register file: one synchronous write port, one asynchronous read port.
module perceptron_sample_buffer #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/perceptron_sample_sequencer.sv
// Buffers a small training set and replays it to a perceptron trainer for a fixed
// number of epochs over a valid/ready stream.
module perceptron_sample_sequencer
  import perceptron_pkg::*;
#(
  parameter int unsigned DATA_W      = perceptron_pkg::DATA_W,
  parameter int unsigned NUM_SAMPLES = perceptron_pkg::NUM_SAMPLES,
  parameter int unsigned NUM_EPOCHS  = perceptron_pkg::NUM_EPOCHS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              clear,
  output logic [$clog2(NUM_EPOCHS+1)-1:0]   epoch,
  output logic                              busy,
  output logic                              done,
  perceptron_sample_sequencer_if.master     bus
);

  localparam int unsigned WORD_W  = 2 * DATA_W + 1;
  localparam int unsigned CNT_W   = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned PTR_W   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam int unsigned EPOCH_W = $clog2(NUM_EPOCHS + 1);

  state_t              state;
  logic [CNT_W-1:0]    count;
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    rd_addr_c;
  logic [WORD_W-1:0]   rd_word_c;
  logic                full_c;
  logic                accept_c;
  logic                launch_c;
  logic                hs_c;
  logic                last_c;

  // rd_addr_c selects the sample to be presented after this edge: next slot while
  // streaming, otherwise slot 0 for a fresh replay.
  always_comb begin
    full_c    = (count == CNT_W'(NUM_SAMPLES));
    accept_c  = (state == ST_LOAD) && bus.load_valid && bus.load_ready && !clear;
    launch_c  = start && !clear && (((state == ST_LOAD) && full_c) || (state == ST_DONE));
    hs_c      = (state == ST_STREAM) && bus.smp_valid && bus.smp_ready;
    last_c    = (rd_ptr == PTR_W'(NUM_SAMPLES - 1));
    rd_addr_c = ((state == ST_STREAM) && !last_c) ? rd_ptr + PTR_W'(1) : '0;
  end

  perceptron_sample_buffer #(
    .DEPTH (NUM_SAMPLES),
    .WIDTH (WORD_W),
    .AW    (PTR_W)
  ) u_buffer (
    .clk     (clk),
    .rst     (rst),
    .we      (accept_c),
    .waddr   (PTR_W'(count)),
    .wdata   (bus.load_data),
    .raddr   (rd_addr_c),
    .rdata_c (rd_word_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_LOAD;
      count          <= '0;
      rd_ptr         <= '0;
      epoch          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.load_ready <= 1'b1;
      bus.smp_valid  <= 1'b0;
      bus.smp_last   <= 1'b0;
      bus.smp_x0     <= '0;
      bus.smp_x1     <= '0;
      bus.smp_label  <= 1'b0;
    end else if (clear) begin
      state          <= ST_LOAD;
      count          <= '0;
      rd_ptr         <= '0;
      epoch          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.load_ready <= 1'b1;
      bus.smp_valid  <= 1'b0;
      bus.smp_last   <= 1'b0;
    end else if (launch_c) begin
      state          <= ST_STREAM;
      rd_ptr         <= '0;
      epoch          <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      bus.smp_valid  <= 1'b1;
      bus.smp_last   <= (rd_addr_c == PTR_W'(NUM_SAMPLES - 1));
      bus.smp_x0     <= rd_word_c[DATA_W-1:0];
      bus.smp_x1     <= rd_word_c[2*DATA_W-1:DATA_W];
      bus.smp_label  <= rd_word_c[2*DATA_W];
    end else if (accept_c) begin
      count          <= count + CNT_W'(1);
      bus.load_ready <= (count < CNT_W'(NUM_SAMPLES - 1));
    end else if (hs_c) begin
      rd_ptr         <= rd_addr_c;
      bus.smp_last   <= (rd_addr_c == PTR_W'(NUM_SAMPLES - 1));
      bus.smp_x0     <= rd_word_c[DATA_W-1:0];
      bus.smp_x1     <= rd_word_c[2*DATA_W-1:DATA_W];
      bus.smp_label  <= rd_word_c[2*DATA_W];
      if (last_c) begin
        epoch <= epoch + EPOCH_W'(1);
        // Final epoch wrapped: stop presenting and latch completion.
        if (epoch == EPOCH_W'(NUM_EPOCHS - 1)) begin
          state         <= ST_DONE;
          busy          <= 1'b0;
          done          <= 1'b1;
          bus.smp_valid <= 1'b0;
          bus.smp_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_perceptron_sample_sequencer.sv
// Scoreboard bench: directed loads/replays push expected samples; a negedge monitor
// pops and compares on every sample handshake and checks stall stability.
module tb_perceptron_sample_sequencer;

  localparam int unsigned DW = 4;

  typedef struct packed {
    logic          label;
    logic [DW-1:0] x1;
    logic [DW-1:0] x0;
    logic          last;
    logic [3:0]    epoch;
  } smp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] epoch;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;

  smp_t exp_q[$];
  smp_t held;
  logic stall_pending = 1'b0;

  perceptron_sample_sequencer_if #(.DATA_W(DW)) bus ();

  perceptron_sample_sequencer #(
    .DATA_W(DW), .NUM_SAMPLES(3), .NUM_EPOCHS(8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .clear (clear),
    .epoch (epoch),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic smp_t cur_smp();
    smp_t s;
    s.label = bus.smp_label;
    s.x1    = bus.smp_x1;
    s.x0    = bus.smp_x0;
    s.last  = bus.smp_last;
    s.epoch = epoch;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst && bus.smp_valid) begin
      smp_t a;
      a = cur_smp();
      if (stall_pending) begin
        checks++;
        if (a !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h expected %h at %0t", a, held, $time);
        end
      end
      if (bus.smp_ready) begin
        smp_t e;
        hs_count++;
        stall_pending = 1'b0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sample: got %h expected none at %0t", a, $time);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL sample_%0d: got lbl=%0d x1=%0d x0=%0d last=%0d ep=%0d expected lbl=%0d x1=%0d x0=%0d last=%0d ep=%0d",
                     hs_count, a.label, a.x1, a.x0, a.last, a.epoch,
                     e.label, e.x1, e.x0, e.last, e.epoch);
          end
        end
      end else begin
        stall_pending = 1'b1;
        held = a;
      end
    end else begin
      stall_pending = 1'b0;
    end
  end

  logic [8:0] words [3];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [8:0] w);
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    step();
    bus.load_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic push_run();
    smp_t e;
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < 3; i++) begin
        e.label = words[i][8];
        e.x1    = words[i][7:4];
        e.x0    = words[i][3:0];
        e.last  = (i == 2);
        e.epoch = 4'(ep);
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    words[0] = {1'b1, 4'd5, 4'd4};
    words[1] = {1'b0, 4'd3, 4'd2};
    words[2] = {1'b1, 4'd9, 4'd7};
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.smp_ready  = 1'b0;

    // Reset state
    #2;
    check("rst_smp_valid", 32'(bus.smp_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_epoch", 32'(epoch), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_load_ready", 32'(bus.load_ready), 1);
    step();

    // Start with a partially filled buffer is ignored
    load_word(words[0]);
    load_word(words[1]);
    check("partial_load_ready", 32'(bus.load_ready), 1);
    pulse_start();
    @(negedge clk);
    check("early_start_valid", 32'(bus.smp_valid), 0);
    check("early_start_busy", 32'(busy), 0);
    step();

    // Fill, then a 4th word must be refused
    load_word(words[2]);
    check("full_load_ready", 32'(bus.load_ready), 0);
    load_word({1'b0, 4'd15, 4'd15});
    check("full_load_ready_after4", 32'(bus.load_ready), 0);

    // Continuous replay
    push_run();
    hs_count = 0;
    pulse_start();
    @(negedge clk);
    check("first_valid", 32'(bus.smp_valid), 1);
    check("first_x0", 32'(bus.smp_x0), 4);
    check("first_x1", 32'(bus.smp_x1), 5);
    check("first_label", 32'(bus.smp_label), 1);
    check("first_busy", 32'(busy), 1);
    step();
    bus.smp_ready = 1'b1;
    for (int c = 0; c < 100 && !done; c++) step();
    bus.smp_ready = 1'b0;
    check("run1_done", 32'(done), 1);
    check("run1_valid", 32'(bus.smp_valid), 0);
    check("run1_busy", 32'(busy), 0);
    check("run1_epoch", 32'(epoch), 8);
    check("run1_handshakes", 32'(hs_count), 24);
    check("run1_queue_left", 32'(exp_q.size()), 0);

    // Clear and reload, then replay with smp_ready toggling every cycle
    clear = 1'b1;
    step();
    clear = 1'b0;
    for (int i = 0; i < 3; i++) load_word(words[i]);
    push_run();
    hs_count = 0;
    pulse_start();
    for (int c = 0; c < 200 && !done; c++) begin
      bus.smp_ready = ~bus.smp_ready;
      step();
    end
    bus.smp_ready = 1'b0;
    check("run2_done", 32'(done), 1);
    check("run2_epoch", 32'(epoch), 8);
    check("run2_handshakes", 32'(hs_count), 24);
    check("run2_queue_left", 32'(exp_q.size()), 0);

    // clear beats start in DONE
    start = 1'b1;
    clear = 1'b1;
    step();
    start = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    check("clr_done", 32'(done), 0);
    check("clr_load_ready", 32'(bus.load_ready), 1);
    check("clr_valid", 32'(bus.smp_valid), 0);
    check("clr_busy", 32'(busy), 0);
    check("clr_epoch", 32'(epoch), 0);
    step();
    @(negedge clk);
    check("clr_valid_later", 32'(bus.smp_valid), 0);
    step();

    // Asynchronous reset during epoch 3
    for (int i = 0; i < 3; i++) load_word(words[i]);
    push_run();
    hs_count = 0;
    pulse_start();
    bus.smp_ready = 1'b1;
    for (int c = 0; c < 50 && hs_count < 10; c++) @(posedge clk);
    #2;
    check("pre_rst_epoch", 32'(epoch), 3);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.smp_valid), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_epoch", 32'(epoch), 0);
    exp_q.delete();
    bus.smp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_load_ready", 32'(bus.load_ready), 1);
    check("post_rst_valid", 32'(bus.smp_valid), 0);
    check("post_rst_done", 32'(done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
